// File: rtl/smc_pkg.sv
// Shared types and constants for the stepper-motor-control SoC masters.
package smc_pkg;

    localparam int unsigned SYSID_DATA_W = 32;

    localparam logic [SYSID_DATA_W-1:0] SMC_SYSID_ID = 32'h0400_0000;
    localparam logic [SYSID_DATA_W-1:0] SMC_SYSID_TS = 32'h5446_1F3B;

    localparam logic SYSID_OFS_ID = 1'b0;
    localparam logic SYSID_OFS_TS = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ID,
        ST_RD_TS,
        ST_COMPARE,
        ST_RETRY,
        ST_DONE,
        ST_FAIL
    } sysid_state_t;

endpackage

// File: rtl/smc_avm_read_timeout.sv
// Single outstanding Avalon-MM read with a stall-cycle timeout.
// launch starts a read on the next cycle; completion/timeout are reported combinationally.
module smc_avm_read_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic launch,
    input  logic launch_addr,
    input  logic avm_waitrequest,
    output logic avm_read,
    output logic avm_address,
    output logic rd_done_c,
    output logic rd_timeout_c
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] stall_cnt;

    // A waitrequest drop on the limit cycle still completes the read.
    assign rd_done_c    = avm_read & ~avm_waitrequest;
    assign rd_timeout_c = avm_read & avm_waitrequest & (stall_cnt == LIMIT_M1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            stall_cnt   <= '0;
        end else if (launch) begin
            avm_read    <= 1'b1;
            avm_address <= launch_addr;
            stall_cnt   <= '0;
        end else if (rd_done_c || rd_timeout_c) begin
            avm_read  <= 1'b0;
            stall_cnt <= '0;
        end else if (avm_read && avm_waitrequest) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/smc_sysid_checker.sv
// Boot-time system-ID verifier: reads sysid ID and timestamp, retries on failure,
// and only allows motor enable once the hardware build is confirmed.
module smc_sysid_checker
    import smc_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = SMC_SYSID_ID,
    parameter logic [31:0] EXPECTED_TS    = SMC_SYSID_TS,
    parameter int unsigned CHECK_TS       = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        mismatch_err,
    output logic        timeout_err,
    output logic [3:0]  retry_count,
    output logic        motor_enable_allow
);

    localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRIES);

    sysid_state_t state;
    logic         start_pending;
    logic         timeout_seen;
    logic         launch_c;
    logic         launch_addr_c;
    logic         rd_done_c;
    logic         rd_timeout_c;
    logic         compare_ok_c;

    smc_avm_read_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rd (
        .clk             (clock),
        .rst_n           (reset_n),
        .launch          (launch_c),
        .launch_addr     (launch_addr_c),
        .avm_waitrequest (avm_waitrequest),
        .avm_read        (avm_read),
        .avm_address     (avm_address),
        .rd_done_c       (rd_done_c),
        .rd_timeout_c    (rd_timeout_c)
    );

    assign compare_ok_c = (id_value == EXPECTED_ID) &&
                          ((CHECK_TS == 0) || (ts_value == EXPECTED_TS));

    // Read launches are issued on the same edge as the state change so no cycle is lost.
    always_comb begin
        launch_c      = 1'b0;
        launch_addr_c = SYSID_OFS_ID;
        case (state)
            ST_IDLE:          launch_c = start_pending | start;
            ST_RD_ID: begin
                launch_c      = rd_done_c;
                launch_addr_c = SYSID_OFS_TS;
            end
            ST_RETRY:         launch_c = (retry_count < RETRY_MAX);
            ST_DONE, ST_FAIL: launch_c = start;
            default:          launch_c = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state              <= ST_IDLE;
            start_pending      <= 1'b1;
            timeout_seen       <= 1'b0;
            id_value           <= '0;
            ts_value           <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            pass               <= 1'b0;
            mismatch_err       <= 1'b0;
            timeout_err        <= 1'b0;
            retry_count        <= '0;
            motor_enable_allow <= 1'b0;
        end else begin
            motor_enable_allow <= done & pass;
            case (state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (launch_c) begin
                        state              <= ST_RD_ID;
                        start_pending      <= 1'b0;
                        timeout_seen       <= 1'b0;
                        retry_count        <= '0;
                        busy               <= 1'b1;
                        done               <= 1'b0;
                        pass               <= 1'b0;
                        mismatch_err       <= 1'b0;
                        timeout_err        <= 1'b0;
                        motor_enable_allow <= 1'b0;
                    end
                end
                ST_RD_ID: begin
                    if (rd_done_c) begin
                        id_value <= avm_readdata;
                        state    <= ST_RD_TS;
                    end else if (rd_timeout_c) begin
                        timeout_seen <= 1'b1;
                        state        <= ST_RETRY;
                    end
                end
                ST_RD_TS: begin
                    if (rd_done_c) begin
                        ts_value <= avm_readdata;
                        state    <= ST_COMPARE;
                    end else if (rd_timeout_c) begin
                        timeout_seen <= 1'b1;
                        state        <= ST_RETRY;
                    end
                end
                ST_COMPARE: begin
                    if (compare_ok_c) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else begin
                        state <= ST_RETRY;
                    end
                end
                ST_RETRY: begin
                    if (launch_c) begin
                        retry_count  <= retry_count + 4'd1;
                        timeout_seen <= 1'b0;
                        state        <= ST_RD_ID;
                    end else begin
                        // Error flag reflects only the cause of the final attempt.
                        state        <= ST_FAIL;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        timeout_err  <= timeout_seen;
                        mismatch_err <= ~timeout_seen;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/smc_sysid_checker.md
Name: smc_sysid_checker

Overview:
- Boot-time system-ID verifier for the stepper-motor-control SoC.
- Avalon-MM read master that sequences two reads of the sysid control slave: word 0 = system ID, word 1 = build timestamp.
- Compares both words against expected constants and gates motor enable until the hardware build is confirmed.
- Sits between the sysid slave (via interconnect) and the motor-control enable logic.

Parameters:
- EXPECTED_ID, 32'h0400_0000, expected word 0.
- EXPECTED_TS, 32'h5446_1F3B, expected word 1.
- CHECK_TS, 1, 1 = timestamp must match; 0 = word 1 is read and reported but not compared.
- TIMEOUT_CYCLES, 255, maximum stalled cycles per read, range 1..65535.
- MAX_RETRIES, 3, full re-read attempts after a failure, range 0..15.

Ports:
- clock, in, 1, single system clock.
- reset_n, in, 1, asynchronous active-low reset.
- start, in, 1, single-cycle pulse; re-runs the check from DONE/FAIL.
- avm_address, out, 1, word select: 0 = ID, 1 = timestamp.
- avm_read, out, 1, Avalon read strobe.
- avm_readdata, in, 32, read data; valid when avm_read=1 and avm_waitrequest=0.
- avm_waitrequest, in, 1, slave stall.
- id_value, out, 32, last captured word 0.
- ts_value, out, 32, last captured word 1.
- busy, out, 1, sequence in progress.
- done, out, 1, sequence finished (pass or fail).
- pass, out, 1, done with all enabled comparisons matching.
- mismatch_err, out, 1, final attempt completed but a value differed.
- timeout_err, out, 1, final attempt aborted by timeout.
- retry_count, out, 4, number of retries used in the current or last run.
- motor_enable_allow, out, 1, registered; equals done & pass.

Behaviour:
- Reset values:
  - All outputs 0 (id_value, ts_value, retry_count included).
  - Internal start_pending = 1, so a check runs automatically after reset.
- FSM states: IDLE, RD_ID, RD_TS, COMPARE, RETRY, DONE, FAIL.
- IDLE: if start_pending or start -> RD_ID; clear start_pending, retry_count, all flags; busy=1.
- RD_ID: avm_address=0, avm_read=1, both held stable while avm_waitrequest=1.
  - On the first cycle with waitrequest=0: capture id_value, go to RD_TS.
- RD_TS: same handshake with avm_address=1; capture ts_value, go to COMPARE.
- avm_read deasserts in COMPARE; no back-to-back reads without a state change.
- Timeout:
  - A per-read counter clears on entry to RD_ID/RD_TS and increments each cycle with waitrequest=1.
  - When it reaches TIMEOUT_CYCLES, drop avm_read (abandon the read), set an internal timeout flag, go to RETRY.
  - A waitrequest drop in the same cycle the counter hits the limit counts as a completed read; the timeout does not fire.
- COMPARE:
  - ok = (id_value==EXPECTED_ID) && (!CHECK_TS || ts_value==EXPECTED_TS).
  - ok -> DONE with pass=1; else -> RETRY.
- RETRY:
  - If retry_count < MAX_RETRIES: retry_count+1, go to RD_ID.
  - Else go to FAIL: set timeout_err or mismatch_err according to the cause of the last attempt; exactly one is set.
- DONE/FAIL: busy=0, done=1; motor_enable_allow follows done & pass one cycle later.
  - start -> IDLE-equivalent restart: flags, done, pass and motor_enable_allow clear the next cycle; id_value and ts_value are held until recaptured.
- start while busy is ignored and not queued.
- Latency with zero wait states, start sampled at cycle 0:
  - avm_read with address 0 at cycle 1, address 1 at cycle 2.
  - COMPARE at cycle 3; done/pass at cycle 4; motor_enable_allow at cycle 5.
- Asynchronous reset mid-read: avm_read drops immediately, and the check reruns automatically after release.
- retry_count saturates at MAX_RETRIES and never wraps.

Decomposition:
- Shared package smc_pkg:
  - FSM state enum sysid_state_t.
  - Default constants SMC_SYSID_ID and SMC_SYSID_TS.
  - Word-offset constants SYSID_OFS_ID=0 and SYSID_OFS_TS=1.
- Optional sub-module smc_avm_read_timeout: single-read Avalon handshake plus timeout counter, reused by other SMC masters.

Test Plan:
- Zero-wait slave returning 32'h0400_0000 / 32'h5446_1F3B, no start pulse after reset -> reads at cycles 1 and 2, done=pass=1 at cycle 4, motor_enable_allow=1 at cycle 5, retry_count=0.
- Slave returns ID 32'h0400_0001 every time, MAX_RETRIES=3 -> 4 read pairs, retry_count=3, FAIL state, mismatch_err=1, pass=0, motor_enable_allow=0.
- waitrequest held high forever, TIMEOUT_CYCLES=8 -> each read is abandoned after 8 stall cycles, final timeout_err=1, avm_read low after abort.
- waitrequest high 5 cycles on the first read, then mismatch once, then correct values -> address held stable while stalled, retry_count=1, pass=1.
- CHECK_TS=0 with a wrong timestamp 32'h0 -> pass=1, ts_value=32'h0.
- reset_n pulsed low during RD_TS stall -> outputs clear asynchronously, automatic recheck passes; start asserted while busy has no effect.
